// File: rtl/nand_ecc_pkg.sv
//==============================================================================
// Module   : nand_ecc_pkg
// Desc     : Shared status codes, FSM states and sizing helper for the NAND ECC engine.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package nand_ecc_pkg;

    localparam logic [1:0] ECC_CLEAN  = 2'b00;
    localparam logic [1:0] ECC_CORR   = 2'b01;
    localparam logic [1:0] ECC_EFIELD = 2'b10;
    localparam logic [1:0] ECC_UNCORR = 2'b11;

    localparam int ECC_W     = 24;
    localparam int COL_PAIRS = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DATA     = 2'd1,
        ST_WAIT_ECC = 2'd2,
        ST_REPORT   = 2'd3
    } ecc_state_t;

    // Number of line-parity pairs (= byte index width) for a chunk size.
    function automatic int line_pairs(input int chunk_bytes);
        return $clog2(chunk_bytes);
    endfunction

endpackage

`default_nettype wire

// File: rtl/nand_ecc_syndrome.sv
//==============================================================================
// Module   : nand_ecc_syndrome
// Desc     : Combinational decode of a 24-bit Hamming syndrome into status and error location.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module nand_ecc_syndrome
    import nand_ecc_pkg::*;
#(
    parameter int CHUNK_BYTES = 512
) (
    input  logic [ECC_W-1:0] syndrome,
    output logic [1:0]       status,
    output logic [8:0]       err_byte,
    output logic [2:0]       err_bit
);

    localparam int LPW   = line_pairs(CHUNK_BYTES);
    localparam int PAIRS = COL_PAIRS + LPW;
    localparam int USED  = 2 * PAIRS;

    logic [PAIRS-1:0] w_pair_diff;
    logic             w_unused_clear;

    generate
        for (genvar k = 0; k < PAIRS; k++) begin : g_pair
            assign w_pair_diff[k] = syndrome[2*k] ^ syndrome[2*k+1];
        end

        // Padding bits are not part of any pair; a correctable pattern leaves them untouched.
        if (USED < ECC_W) begin : g_partial
            assign w_unused_clear = ~|syndrome[ECC_W-1:USED];
        end else begin : g_full
            assign w_unused_clear = 1'b1;
        end
    endgenerate

    always_comb begin
        err_byte = '0;
        for (int k = 0; k < LPW; k++) begin
            err_byte[k] = syndrome[7+2*k];
        end
        err_bit = {syndrome[5], syndrome[3], syndrome[1]};

        if (syndrome == '0) begin
            status = ECC_CLEAN;
        end else if ((&w_pair_diff) && w_unused_clear) begin
            status = ECC_CORR;
        end else if ($onehot(syndrome)) begin
            status = ECC_EFIELD;
        end else begin
            status = ECC_UNCORR;
        end
    end

endmodule

`default_nettype wire

// File: rtl/nand_ecc_engine.sv
//==============================================================================
// Module   : nand_ecc_engine
// Desc     : Streaming Hamming SEC/DED generate (program) / check (read) over NAND page chunks.
//            Optional build macro: NAND_ECC_ERASED_DETECT_EN (erased-chunk reported clean).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module nand_ecc_engine
    import nand_ecc_pkg::*;
#(
    parameter int CHUNK_BYTES     = 512,
    parameter int CHUNKS_PER_PAGE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              ecc_in_valid,
    output logic              ecc_in_ready,
    input  logic [ECC_W-1:0]  ecc_in,
    output logic              result_valid,
    output logic [ECC_W-1:0]  ecc_out,
    output logic [1:0]        status,
    output logic [8:0]        err_byte,
    output logic [2:0]        err_bit,
    output logic [3:0]        chunk_idx,
    output logic              page_done,
    output logic [1:0]        page_status,
    output logic              busy
);

    localparam int LPW = line_pairs(CHUNK_BYTES);

    localparam logic [LPW-1:0]     c_last_byte  = LPW'(CHUNK_BYTES - 1);
    localparam logic [3:0]         c_last_chunk = 4'(CHUNKS_PER_PAGE - 1);
    localparam logic [2:0][7:0]    c_col_mask   = {8'hF0, 8'hCC, 8'hAA};

    ecc_state_t       r_state;
    ecc_state_t       w_state_next;
    logic             r_mode;
    logic [LPW-1:0]   r_byte_cnt;
    logic [3:0]       r_chunk;
    logic [LPW-1:0]   r_lp0, r_lp1, w_lp0_next, w_lp1_next;
    logic [2:0]       r_cp0, r_cp1, w_cp0_next, w_cp1_next;
    logic [2:0]       w_col0, w_col1;
    logic             w_byte_par;

    logic             w_byte_xfer;
    logic             w_ecc_xfer;
    logic             w_last_byte;
    logic             w_last_chunk;
    logic             w_start_go;
    logic             w_clear;
    logic             w_enc_done;
    logic             w_erased;

    logic [ECC_W-1:0] w_ecc_acc;
    logic [ECC_W-1:0] w_ecc_upd;
    logic [ECC_W-1:0] w_syndrome;
    logic [1:0]       w_syn_status;
    logic [1:0]       w_res_status;
    logic [8:0]       w_syn_err_byte;
    logic [2:0]       w_syn_err_bit;

    logic [ECC_W-1:0] r_ecc_out;
    logic [1:0]       r_status;
    logic [8:0]       r_err_byte;
    logic [2:0]       r_err_bit;
    logic [3:0]       r_chunk_idx;
    logic [1:0]       r_page_status;

    function automatic logic [ECC_W-1:0] pack_ecc(
        input logic [LPW-1:0] lp0,
        input logic [LPW-1:0] lp1,
        input logic [2:0]     cp0,
        input logic [2:0]     cp1
    );
        logic [ECC_W-1:0] e;
        e = '1;
        for (int k = 0; k < COL_PAIRS; k++) begin
            e[2*k]   = cp0[k];
            e[2*k+1] = cp1[k];
        end
        for (int k = 0; k < LPW; k++) begin
            e[6+2*k] = lp0[k];
            e[7+2*k] = lp1[k];
        end
        return e;
    endfunction

    //--------------------------------------------------------------------------
    // FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        ecc_in_ready = 1'b0;
        result_valid = 1'b0;
        page_done    = 1'b0;
        busy         = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                in_ready = ~abort;
                if (in_valid && w_last_byte) begin
                    w_state_next = r_mode ? ST_WAIT_ECC : ST_REPORT;
                end
            end
            ST_WAIT_ECC: begin
                ecc_in_ready = ~abort;
                if (ecc_in_valid) begin
                    w_state_next = ST_REPORT;
                end
            end
            ST_REPORT: begin
                result_valid = ~abort;
                page_done    = ~abort & w_last_chunk;
                w_state_next = w_last_chunk ? ST_IDLE : ST_DATA;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (abort) begin
            w_state_next = ST_IDLE;
        end
    end

    assign w_byte_xfer  = in_valid & in_ready;
    assign w_ecc_xfer   = ecc_in_valid & ecc_in_ready;
    assign w_last_byte  = (r_byte_cnt == c_last_byte);
    assign w_last_chunk = (r_chunk == c_last_chunk);
    assign w_start_go   = (r_state == ST_IDLE) & start & ~abort;
    assign w_clear      = w_start_go | (r_state == ST_REPORT) | abort;
    assign w_enc_done   = w_byte_xfer & w_last_byte & ~r_mode;

    //--------------------------------------------------------------------------
    // Parity accumulation
    //--------------------------------------------------------------------------
    assign w_byte_par = ^in_data;

    generate
        for (genvar k = 0; k < COL_PAIRS; k++) begin : g_col
            assign w_col1[k] = ^(in_data &  c_col_mask[k]);
            assign w_col0[k] = ^(in_data & ~c_col_mask[k]);
        end
    endgenerate

    always_comb begin
        w_lp0_next = r_lp0;
        w_lp1_next = r_lp1;
        w_cp0_next = r_cp0;
        w_cp1_next = r_cp1;
        if (w_clear) begin
            w_lp0_next = '0;
            w_lp1_next = '0;
            w_cp0_next = '0;
            w_cp1_next = '0;
        end else if (w_byte_xfer) begin
            // Line pair k picks its half by bit k of the byte index.
            w_lp1_next = r_lp1 ^ ( r_byte_cnt & {LPW{w_byte_par}});
            w_lp0_next = r_lp0 ^ (~r_byte_cnt & {LPW{w_byte_par}});
            w_cp1_next = r_cp1 ^ w_col1;
            w_cp0_next = r_cp0 ^ w_col0;
        end
    end

    assign w_ecc_acc  = pack_ecc(r_lp0, r_lp1, r_cp0, r_cp1);
    assign w_ecc_upd  = pack_ecc(w_lp0_next, w_lp1_next, w_cp0_next, w_cp1_next);
    assign w_syndrome = w_ecc_acc ^ ecc_in;

    nand_ecc_syndrome #(
        .CHUNK_BYTES (CHUNK_BYTES)
    ) u_syndrome (
        .syndrome (w_syndrome),
        .status   (w_syn_status),
        .err_byte (w_syn_err_byte),
        .err_bit  (w_syn_err_bit)
    );

`ifdef NAND_ECC_ERASED_DETECT_EN
    logic r_all_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_all_ff <= 1'b0;
        end else if (w_clear) begin
            r_all_ff <= 1'b1;
        end else if (w_byte_xfer) begin
            r_all_ff <= r_all_ff & (in_data == 8'hFF);
        end
    end

    assign w_erased = r_all_ff & (ecc_in == {ECC_W{1'b1}});
`else
    assign w_erased = 1'b0;
`endif

    assign w_res_status = w_erased ? ECC_CLEAN : w_syn_status;

    //--------------------------------------------------------------------------
    // Counters and result registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode        <= 1'b0;
            r_byte_cnt    <= '0;
            r_chunk       <= '0;
            r_lp0         <= '0;
            r_lp1         <= '0;
            r_cp0         <= '0;
            r_cp1         <= '0;
            r_ecc_out     <= '0;
            r_status      <= ECC_CLEAN;
            r_err_byte    <= '0;
            r_err_bit     <= '0;
            r_chunk_idx   <= '0;
            r_page_status <= ECC_CLEAN;
        end else begin
            r_lp0 <= w_lp0_next;
            r_lp1 <= w_lp1_next;
            r_cp0 <= w_cp0_next;
            r_cp1 <= w_cp1_next;

            if (w_clear) begin
                r_byte_cnt <= '0;
            end else if (w_byte_xfer) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end

            if (w_start_go) begin
                r_mode        <= mode;
                r_chunk       <= '0;
                r_page_status <= ECC_CLEAN;
            end else if (r_state == ST_REPORT) begin
                r_chunk <= r_chunk + 4'd1;
            end

            if (w_enc_done) begin
                r_ecc_out   <= w_ecc_upd;
                r_status    <= ECC_CLEAN;
                r_err_byte  <= '0;
                r_err_bit   <= '0;
                r_chunk_idx <= r_chunk;
            end

            if (w_ecc_xfer) begin
                r_ecc_out   <= w_ecc_acc;
                r_status    <= w_res_status;
                r_err_byte  <= w_erased ? 9'd0 : w_syn_err_byte;
                r_err_bit   <= w_erased ? 3'd0 : w_syn_err_bit;
                r_chunk_idx <= r_chunk;
                if (w_res_status > r_page_status) begin
                    r_page_status <= w_res_status;
                end
            end
        end
    end

    assign ecc_out     = r_ecc_out;
    assign status      = r_status;
    assign err_byte    = r_err_byte;
    assign err_bit     = r_err_bit;
    assign chunk_idx   = r_chunk_idx;
    assign page_status = r_page_status;

endmodule

`default_nettype wire

// File: tb/tb_nand_ecc_engine.sv
//==============================================================================
// Module   : tb_nand_ecc_engine
// Desc     : Directed self-checking bench for nand_ecc_engine (512-byte chunks, 4 per page).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_nand_ecc_engine;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        ecc_in_valid;
    logic        ecc_in_ready;
    logic [23:0] ecc_in;
    logic        result_valid;
    logic [23:0] ecc_out;
    logic [1:0]  status;
    logic [8:0]  err_byte;
    logic [2:0]  err_bit;
    logic [3:0]  chunk_idx;
    logic        page_done;
    logic [1:0]  page_status;
    logic        busy;

    int total = 0;
    int bad   = 0;

    nand_ecc_engine #(
        .CHUNK_BYTES     (512),
        .CHUNKS_PER_PAGE (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mode         (mode),
        .abort        (abort),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .ecc_in_valid (ecc_in_valid),
        .ecc_in_ready (ecc_in_ready),
        .ecc_in       (ecc_in),
        .result_valid (result_valid),
        .ecc_out      (ecc_out),
        .status       (status),
        .err_byte     (err_byte),
        .err_bit      (err_bit),
        .chunk_idx    (chunk_idx),
        .page_done    (page_done),
        .page_status  (page_status),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Data patterns: 0 zeros, 1 byte5=08, 2 byte0=01/byte1=02, 3 all FF, 4 byte300=80
    function automatic logic [7:0] byte_of(input int kind, input int i);
        case (kind)
            1:       return (i == 5) ? 8'h08 : 8'h00;
            2:       return (i == 0) ? 8'h01 : ((i == 1) ? 8'h02 : 8'h00);
            3:       return 8'hFF;
            4:       return (i == 300) ? 8'h80 : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    task automatic begin_page(input string tag, input logic m);
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = 1'b0;
        chk({tag, ".busy"}, busy, 1);
    endtask

    task automatic run_chunk(
        input string       tag,
        input int          kind,
        input logic        chk_mode,
        input logic [23:0] ecc_val,
        input logic [23:0] exp_ecc,
        input logic [1:0]  exp_st,
        input logic [8:0]  exp_byte,
        input logic [2:0]  exp_bit,
        input logic [3:0]  exp_idx,
        input logic        last,
        input logic [1:0]  exp_pstat
    );
        for (int i = 0; i < 512; i++) begin
            in_valid = 1'b1;
            in_data  = byte_of(kind, i);
            if (i == 0) chk({tag, ".in_ready"}, in_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        if (chk_mode) begin
            chk({tag, ".ecc_rdy"}, ecc_in_ready, 1);
            chk({tag, ".rv_early"}, result_valid, 0);
            ecc_in_valid = 1'b1;
            ecc_in       = ecc_val;
            @(posedge clk); #1;
            ecc_in_valid = 1'b0;
            ecc_in       = 24'h0;
        end
        chk({tag, ".rv"}, result_valid, 1);
        chk({tag, ".ecc"}, ecc_out, exp_ecc);
        chk({tag, ".status"}, status, exp_st);
        chk({tag, ".idx"}, chunk_idx, exp_idx);
        chk({tag, ".pdone"}, page_done, last);
        if (exp_st == 2'b01) begin
            chk({tag, ".err_byte"}, err_byte, exp_byte);
            chk({tag, ".err_bit"}, err_bit, exp_bit);
        end
        if (last) chk({tag, ".pstat"}, page_status, exp_pstat);
        @(posedge clk); #1;
        chk({tag, ".rv_pulse"}, result_valid, 0);
        chk({tag, ".busy_after"}, busy, !last);
    endtask

    logic [1:0] erased_exp;
    logic       seen;

    initial begin
`ifdef NAND_ECC_ERASED_DETECT_EN
        erased_exp = 2'b00;
`else
        erased_exp = 2'b11;
`endif
        rst_n        = 1'b0;
        start        = 1'b0;
        mode         = 1'b0;
        abort        = 1'b0;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        ecc_in_valid = 1'b0;
        ecc_in       = 24'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", busy, 0);
        chk("rst.in_ready", in_ready, 0);
        chk("rst.ecc_rdy", ecc_in_ready, 0);
        chk("rst.rv", result_valid, 0);
        chk("rst.pdone", page_done, 0);
        chk("rst.ecc", ecc_out, 0);
        chk("rst.status", status, 0);
        chk("rst.err_byte", err_byte, 0);
        chk("rst.err_bit", err_bit, 0);
        chk("rst.idx", chunk_idx, 0);
        chk("rst.pstat", page_status, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Encode page: hand-derived ECC for each pattern
        begin_page("encA", 1'b0);
        run_chunk("encA0", 0, 1'b0, 24'h0, 24'h000000, 2'b00, 9'd0, 3'd0, 4'd0, 1'b0, 2'b00);
        run_chunk("encA1", 1, 1'b0, 24'h0, 24'h55599A, 2'b00, 9'd0, 3'd0, 4'd1, 1'b0, 2'b00);
        run_chunk("encA2", 4, 1'b0, 24'h0, 24'h96696A, 2'b00, 9'd0, 3'd0, 4'd2, 1'b0, 2'b00);
        run_chunk("encA3", 2, 1'b0, 24'h0, 24'h0000C3, 2'b00, 9'd0, 3'd0, 4'd3, 1'b1, 2'b00);

        // Check page: single-bit, ECC-field, high-index single-bit, double-bit
        begin_page("chkB", 1'b1);
        run_chunk("chkB0", 1, 1'b1, 24'h000000, 24'h55599A, 2'b01, 9'd5,   3'd3, 4'd0, 1'b0, 2'b00);
        run_chunk("chkB1", 0, 1'b1, 24'h000001, 24'h000000, 2'b10, 9'd0,   3'd0, 4'd1, 1'b0, 2'b00);
        run_chunk("chkB2", 4, 1'b1, 24'h000000, 24'h96696A, 2'b01, 9'd300, 3'd7, 4'd2, 1'b0, 2'b00);
        run_chunk("chkB3", 2, 1'b1, 24'h000000, 24'h0000C3, 2'b11, 9'd0,   3'd0, 4'd3, 1'b1, 2'b11);

        // Check page: erased chunk, clean chunk, then abort inside chunk 2
        begin_page("chkC", 1'b1);
        run_chunk("chkC0", 3, 1'b1, 24'hFFFFFF, 24'h000000, erased_exp, 9'd0, 3'd0, 4'd0, 1'b0, 2'b00);
        run_chunk("chkC1", 0, 1'b1, 24'h000000, 24'h000000, 2'b00,      9'd0, 3'd0, 4'd1, 1'b0, 2'b00);
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h00;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        abort    = 1'b1;
        #1;
        chk("abort.ready_gated", in_ready, 0);
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort.busy", busy, 0);
        chk("abort.in_ready", in_ready, 0);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (result_valid || page_done) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("abort.no_result", seen, 0);

        // Fresh encode page after abort restarts chunk numbering
        begin_page("encD", 1'b0);
        run_chunk("encD0", 0, 1'b0, 24'h0, 24'h000000, 2'b00, 9'd0, 3'd0, 4'd0, 1'b0, 2'b00);
        run_chunk("encD1", 0, 1'b0, 24'h0, 24'h000000, 2'b00, 9'd0, 3'd0, 4'd1, 1'b0, 2'b00);
        run_chunk("encD2", 0, 1'b0, 24'h0, 24'h000000, 2'b00, 9'd0, 3'd0, 4'd2, 1'b0, 2'b00);
        run_chunk("encD3", 1, 1'b0, 24'h0, 24'h55599A, 2'b00, 9'd0, 3'd0, 4'd3, 1'b1, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
